// File: rtl/triple_buffer_scheduler_if.sv
// ---------------------------------------------------------------------------
// triple_buffer_scheduler_if
//
// Groups the camera/VGA sync inputs and the bank-role outputs of the
// triple-buffer scheduler. clk_in and reset stay plain ports on the module.
//
// Signals:
//   cam_vsync, cam_href  camera sync levels, already in the clk_in domain
//   vga_vsync            VGA vsync level; rising edge = VGA frame end
//   freeze               hold the current read bank
//   wr_bank/rd_bank/spare_bank  bank roles (0=x, 1=y, 2=z)
//   cam_wr_en            camera capture into wr_bank permitted
//   fresh                spare_bank holds a frame newer than rd_bank
//   swap_pulse           one-cycle strobe on any rd_bank change
//   cam_state            debug view of the camera FSM state
//   frames_*             statistics counters (only with SCHED_STATS_EN)
//
// Modports: master drives the sync inputs and observes the roles;
//           slave is the scheduler itself.
// ---------------------------------------------------------------------------
interface triple_buffer_scheduler_if;
  logic       cam_vsync;
  logic       cam_href;
  logic       vga_vsync;
  logic       freeze;
  logic [1:0] wr_bank;
  logic [1:0] rd_bank;
  logic [1:0] spare_bank;
  logic       cam_wr_en;
  logic       fresh;
  logic       swap_pulse;
  logic [1:0] cam_state;
`ifdef SCHED_STATS_EN
  logic [15:0] frames_done;
  logic [15:0] frames_dropped;
  logic [15:0] frames_skipped;

  modport master (
    output cam_vsync, cam_href, vga_vsync, freeze,
    input  wr_bank, rd_bank, spare_bank, cam_wr_en, fresh, swap_pulse,
    input  cam_state,
    input  frames_done, frames_dropped, frames_skipped
  );

  modport slave (
    input  cam_vsync, cam_href, vga_vsync, freeze,
    output wr_bank, rd_bank, spare_bank, cam_wr_en, fresh, swap_pulse,
    output cam_state,
    output frames_done, frames_dropped, frames_skipped
  );
`else
  modport master (
    output cam_vsync, cam_href, vga_vsync, freeze,
    input  wr_bank, rd_bank, spare_bank, cam_wr_en, fresh, swap_pulse,
    input  cam_state
  );

  modport slave (
    input  cam_vsync, cam_href, vga_vsync, freeze,
    output wr_bank, rd_bank, spare_bank, cam_wr_en, fresh, swap_pulse,
    output cam_state
  );
`endif
endinterface

// File: rtl/triple_buffer_scheduler.sv
// ---------------------------------------------------------------------------
// triple_buffer_scheduler
//
// Assigns the three frame SRAMs (0=x, 1=y, 2=z) to the roles camera-write,
// VGA-read and spare. A camera frame that completes (enough href lines
// between vsync edges) is swapped into spare; a VGA frame end pulls a fresh
// spare into the read role, so VGA always shows the newest complete frame
// and never a frame that is still being written.
//
// Ports:
//   clk_in  system clock
//   reset   synchronous, active-high reset
//   sched   triple_buffer_scheduler_if.slave (sync inputs, bank roles,
//           debug FSM state, optional statistics)
//
// Parameters:
//   MIN_LINES   href rising edges needed for a frame to count as complete
//   LINE_CNT_W  width of the saturating line counter
//
// Optional feature: define SCHED_STATS_EN to add the frames_done,
// frames_dropped and frames_skipped 16-bit wrapping counters.
//
// Signalling: all sync inputs are plain levels sampled every cycle; there
// is no valid/ready handshake. swap_pulse is a valid-only strobe with no
// ready: a consumer must act in the single cycle it is high.
// ---------------------------------------------------------------------------
module triple_buffer_scheduler #(
  parameter int MIN_LINES  = 1,
  parameter int LINE_CNT_W = 10
) (
  input logic                        clk_in,
  input logic                        reset,
  triple_buffer_scheduler_if.slave   sched
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    ARMED     = 2'd1,
    CAPTURING = 2'd2
  } cam_state_t;

  localparam logic [LINE_CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [LINE_CNT_W-1:0] MIN_LINES_W = LINE_CNT_W'(MIN_LINES);

  cam_state_t            state;
  logic [LINE_CNT_W-1:0] line_cnt;

  logic cam_vsync_q;
  logic cam_href_q;
  logic vga_vsync_q;

  logic [1:0] wr_bank_r;
  logic [1:0] rd_bank_r;
  logic [1:0] spare_bank_r;
  logic       cam_wr_en_r;
  logic       fresh_r;
  logic       swap_pulse_r;

  // Edge decode on the registered copies; an edge seen in cycle k updates
  // the registered outputs at the edge ending cycle k.
  logic cam_rise;
  logic cam_fall;
  logic href_rise;
  logic vga_end;
  logic frame_end;
  logic cam_done;
  logic cam_drop;
  logic vga_takes;

  assign cam_rise  = sched.cam_vsync & ~cam_vsync_q;
  assign cam_fall  = ~sched.cam_vsync & cam_vsync_q;
  assign href_rise = sched.cam_href & ~cam_href_q;
  assign vga_end   = sched.vga_vsync & ~vga_vsync_q;

  assign frame_end = (state == CAPTURING) && cam_rise;
  assign cam_done  = frame_end && (line_cnt >= MIN_LINES_W);
  assign cam_drop  = frame_end && (line_cnt < MIN_LINES_W);
  // VGA frame end acts only when unfrozen; with a simultaneous cam_done the
  // just-finished frame goes straight to the reader regardless of fresh.
  assign vga_takes = vga_end && !sched.freeze;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= WAIT_SYNC;
      line_cnt     <= '0;
      cam_vsync_q  <= 1'b0;
      cam_href_q   <= 1'b0;
      vga_vsync_q  <= 1'b0;
      wr_bank_r    <= 2'd0;
      rd_bank_r    <= 2'd1;
      spare_bank_r <= 2'd2;
      cam_wr_en_r  <= 1'b0;
      fresh_r      <= 1'b0;
      swap_pulse_r <= 1'b0;
    end else begin
      cam_vsync_q  <= sched.cam_vsync;
      cam_href_q   <= sched.cam_href;
      vga_vsync_q  <= sched.vga_vsync;
      swap_pulse_r <= 1'b0;

      // Camera frame tracking. WAIT_SYNC throws away whatever partial frame
      // was in flight at reset by waiting for a full blanking interval.
      case (state)
        WAIT_SYNC: begin
          cam_wr_en_r <= 1'b0;
          if (cam_rise) state <= ARMED;
        end
        ARMED: begin
          if (cam_fall) begin
            state       <= CAPTURING;
            line_cnt    <= '0;
            cam_wr_en_r <= 1'b1;
          end
        end
        CAPTURING: begin
          if (href_rise && (line_cnt != CNT_MAX)) line_cnt <= line_cnt + 1'b1;
          if (cam_rise) begin
            state       <= ARMED;
            cam_wr_en_r <= 1'b0;
          end
        end
        default: begin
          state       <= WAIT_SYNC;
          cam_wr_en_r <= 1'b0;
        end
      endcase

      // Bank rotation. Every branch is a swap of two roles, so the three
      // banks always stay a permutation of {0,1,2}.
      if (cam_done && vga_takes) begin
        rd_bank_r    <= wr_bank_r;
        wr_bank_r    <= rd_bank_r;
        fresh_r      <= 1'b0;
        swap_pulse_r <= 1'b1;
      end else if (cam_done) begin
        wr_bank_r    <= spare_bank_r;
        spare_bank_r <= wr_bank_r;
        fresh_r      <= 1'b1;
      end else if (vga_takes && fresh_r) begin
        rd_bank_r    <= spare_bank_r;
        spare_bank_r <= rd_bank_r;
        fresh_r      <= 1'b0;
        swap_pulse_r <= 1'b1;
      end
    end
  end

  assign sched.wr_bank    = wr_bank_r;
  assign sched.rd_bank    = rd_bank_r;
  assign sched.spare_bank = spare_bank_r;
  assign sched.cam_wr_en  = cam_wr_en_r;
  assign sched.fresh      = fresh_r;
  assign sched.swap_pulse = swap_pulse_r;
  assign sched.cam_state  = state;

`ifdef SCHED_STATS_EN
  logic [15:0] frames_done_r;
  logic [15:0] frames_dropped_r;
  logic [15:0] frames_skipped_r;

  // A cam_done while fresh is set means the previous fresh frame is never
  // shown: either it is overwritten in spare, or the reader jumps past it.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      frames_done_r    <= 16'd0;
      frames_dropped_r <= 16'd0;
      frames_skipped_r <= 16'd0;
    end else begin
      if (cam_done)            frames_done_r    <= frames_done_r + 16'd1;
      if (cam_drop)            frames_dropped_r <= frames_dropped_r + 16'd1;
      if (cam_done && fresh_r) frames_skipped_r <= frames_skipped_r + 16'd1;
    end
  end

  assign sched.frames_done    = frames_done_r;
  assign sched.frames_dropped = frames_dropped_r;
  assign sched.frames_skipped = frames_skipped_r;
`endif

endmodule

// File: tb/tb_triple_buffer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_triple_buffer_scheduler
//
// Directed bench for triple_buffer_scheduler. The stimulus process pushes
// the expected output snapshot, tagged with the cycle it must appear in,
// into exp_q; the monitor pops and compares on every change of the DUT's
// visible outputs. Any unexpected change, wrong value or wrong cycle shows
// up as a FAIL line.
// ---------------------------------------------------------------------------
module tb_triple_buffer_scheduler;

  localparam int W = 25;  // {cycle[15:0], wr, rd, spare, fresh, swap, en}

  logic clk_in;
  logic reset;
  int   cyc;
  int   passed;
  int   total;
  logic mon_en;

  logic [W-1:0] exp_q[$];
  logic [8:0]   prev_snap;

  triple_buffer_scheduler_if sif ();

  triple_buffer_scheduler dut (
    .clk_in (clk_in),
    .reset  (reset),
    .sched  (sif)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pk(input int c, input logic [1:0] w,
                                      input logic [1:0] r, input logic [1:0] s,
                                      input logic f, input logic sp,
                                      input logic en);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, w, r, s, f, sp, en};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic exp_at(input int off, input logic [1:0] w, input logic [1:0] r,
                        input logic [1:0] s, input logic f, input logic sp,
                        input logic en);
    exp_q.push_back(pk(cyc + off, w, r, s, f, sp, en));
  endtask

  task automatic href_pulse();
    sif.cam_href = 1'b1;
    step();
    sif.cam_href = 1'b0;
    step();
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_in) begin
    logic [8:0]   snap;
    logic [W-1:0] got;
    logic [W-1:0] item;
    logic         perm_ok;
    if (mon_en) begin
      snap = {sif.wr_bank, sif.rd_bank, sif.spare_bank, sif.fresh,
              sif.swap_pulse, sif.cam_wr_en};
      if (snap !== prev_snap) begin
        got = pk(cyc, sif.wr_bank, sif.rd_bank, sif.spare_bank, sif.fresh,
                 sif.swap_pulse, sif.cam_wr_en);
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change: got cyc=%0d snap=%b, required no change",
                   cyc, snap);
        end else begin
          item = exp_q.pop_front();
          if (item === got) passed++;
          else $display("FAIL scoreboard: got cyc=%0d snap=%b, required cyc=%0d snap=%b",
                        got[W-1:9], got[8:0], item[W-1:9], item[8:0]);
        end
        perm_ok = (sif.wr_bank != 2'd3) && (sif.rd_bank != 2'd3) &&
                  (sif.spare_bank != 2'd3) && (sif.wr_bank != sif.rd_bank) &&
                  (sif.wr_bank != sif.spare_bank) && (sif.rd_bank != sif.spare_bank);
        total++;
        if (perm_ok) passed++;
        else $display("FAIL bank_permutation: got wr=%0d rd=%0d spare=%0d, required permutation of 0,1,2",
                      sif.wr_bank, sif.rd_bank, sif.spare_bank);
        prev_snap = snap;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    passed        = 0;
    total         = 0;
    mon_en        = 1'b0;
    prev_snap     = {2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    reset         = 1'b1;
    sif.cam_vsync = 1'b0;
    sif.cam_href  = 1'b0;
    sif.vga_vsync = 1'b0;
    sif.freeze    = 1'b0;
    repeat (3) step();

    chk("reset_wr_bank",    16'(sif.wr_bank),    16'd0);
    chk("reset_rd_bank",    16'(sif.rd_bank),    16'd1);
    chk("reset_spare_bank", 16'(sif.spare_bank), 16'd2);
    chk("reset_cam_wr_en",  16'(sif.cam_wr_en),  16'd0);
    chk("reset_fresh",      16'(sif.fresh),      16'd0);
    chk("reset_swap_pulse", 16'(sif.swap_pulse), 16'd0);
    chk("reset_cam_state",  16'(sif.cam_state),  16'd0);

    reset  = 1'b0;
    mon_en = 1'b1;
    step();

    // 1: one complete 3-line frame, then a VGA frame end takes it.
    sif.cam_vsync = 1'b1; step(); step();
    exp_at(1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1);
    sif.cam_vsync = 1'b0; step();
    repeat (3) href_pulse();
    exp_at(1, 2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    sif.cam_vsync = 1'b1; step(); step();
    exp_at(1, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0);
    exp_at(2, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    sif.vga_vsync = 1'b1; step(); step();
    // second VGA frame end with nothing fresh: no change expected
    sif.vga_vsync = 1'b0; step();
    sif.vga_vsync = 1'b1; step(); step();
    sif.vga_vsync = 1'b0; step();

    // 2: reset mid-frame; href activity alone must not restart capture.
    exp_at(1, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);
    sif.cam_vsync = 1'b0; step();
    href_pulse();
    sif.cam_href = 1'b1;
    exp_at(1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; step(); step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sif.cam_href  = ~sif.cam_href;
      sif.vga_vsync = (i == 2);
      step();
    end
    chk("en_after_reset", 16'(sif.cam_wr_en), 16'd0);
    sif.cam_href  = 1'b0;
    sif.vga_vsync = 1'b0;
    sif.cam_vsync = 1'b1; step(); step();
    exp_at(1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1);
    sif.cam_vsync = 1'b0; step();
    repeat (2) href_pulse();
    exp_at(1, 2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    sif.cam_vsync = 1'b1; step(); step();

    // 3: zero-line frame is dropped; banks and fresh hold.
    exp_at(1, 2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1);
    sif.cam_vsync = 1'b0; step();
    repeat (3) step();
    exp_at(1, 2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    sif.cam_vsync = 1'b1; step(); step();
`ifdef SCHED_STATS_EN
    chk("stats_dropped_short", sif.frames_dropped, 16'd1);
    chk("stats_done_short",    sif.frames_done,    16'd1);
    chk("stats_skipped_short", sif.frames_skipped, 16'd0);
`endif

    // 4: cam_done and VGA frame end in the same cycle from reset roles.
    exp_at(1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; step();
    reset = 1'b0; step();
    exp_at(1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1);
    sif.cam_vsync = 1'b0; step();
    href_pulse();
    exp_at(1, 2'd1, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0);
    exp_at(2, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    sif.cam_vsync = 1'b1;
    sif.vga_vsync = 1'b1;
    step(); step();
    sif.vga_vsync = 1'b0; step();

    // 5: freeze across two complete frames, then release.
    sif.freeze = 1'b1;
    exp_at(1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; step();
    reset = 1'b0; step();
    exp_at(1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1);
    sif.cam_vsync = 1'b0; step();
    href_pulse();
    exp_at(1, 2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    sif.cam_vsync = 1'b1; step(); step();
    exp_at(1, 2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1);
    sif.cam_vsync = 1'b0; step();
    href_pulse();
    exp_at(1, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
    sif.cam_vsync = 1'b1; step(); step();
    sif.vga_vsync = 1'b1; step(); step();
    chk("frozen_rd_bank", 16'(sif.rd_bank), 16'd1);
    chk("frozen_fresh",   16'(sif.fresh),   16'd1);
`ifdef SCHED_STATS_EN
    chk("stats_skipped_frozen", sif.frames_skipped, 16'd1);
    chk("stats_done_frozen",    sif.frames_done,    16'd2);
    chk("stats_dropped_frozen", sif.frames_dropped, 16'd0);
`endif
    sif.vga_vsync = 1'b0; step();
    sif.freeze    = 1'b0; step();
    exp_at(1, 2'd0, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0);
    exp_at(2, 2'd0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    sif.vga_vsync = 1'b1; step(); step(); step();
    sif.vga_vsync = 1'b0; step(); step();

    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
